vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the VGA raster timing consumed by the board renderer. The block divides the system clock into a pixel enable, runs horizontal and vertical counters, and drives the current pixel coordinates `x`/`y` to the renderer. It returns the renderer's registered RGB to the DAC/connector with sync and blank signals delayed to match, so colour and sync leave the chip on the same edge. It sits between the top level (clock, reset, VGA pins) and the pixel renderer.

## Interface
Parameters:
- `HRES`, 640, visible pixels per line
- `VRES`, 480, visible lines per frame
- `H_FP`/`H_SYNC`/`H_BP`, 16/96/48, horizontal front porch, sync and back porch, in pixels
- `V_FP`/`V_SYNC`/`V_BP`, 10/2/33, vertical front porch, sync and back porch, in lines
- `PIX_DIV`, 2, `clk` cycles per pixel; must be ≥ 2
- `RENDER_LAT`, 1, `clk` cycles from `x`/`y` to valid `in_*` RGB; must be ≥ 1

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `x`  out  10  horizontal counter, 0..H_TOTAL-1
- `y`  out  10  vertical counter, 0..V_TOTAL-1
- `pix_en`  out  1  one-`clk` pulse when counters advance
- `line_start`  out  1  pulse with `pix_en` when `x` wraps to 0
- `frame_start`  out  1  pulse with `pix_en` when `x` and `y` both wrap to 0
- `in_red`/`in_green`/`in_blue`  in  8 each  renderer colour
- `red`/`green`/`blue`  out  8 each  colour to DAC
- `hsync`, `vsync`  out  1  active-low sync
- `blank_n`  out  1  high in the visible area
- `sync_n`  out  1  constant 0 (no sync-on-green)
- `vga_clk`  out  1  DAC pixel clock

## Operation
- H_TOTAL = HRES+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL similarly (525 by default).
- Divider `div` counts 0..PIX_DIV-1 and wraps. `pix_en` is registered high for the one `clk` in which `div == PIX_DIV-1`.
- On `pix_en`:
  - `x` increments.
  - At `x == H_TOTAL-1`, `x` wraps to 0 and `y` increments.
  - At `y == V_TOTAL-1` with the line wrap, `y` wraps to 0.
  - `line_start`/`frame_start` are asserted in the same cycle as the wrap.
- Raw timing decoded from the counters:
  - hsync low for `HRES+H_FP ≤ x < HRES+H_FP+H_SYNC`, i.e. 656..751.
  - vsync low for `VRES+V_FP ≤ y < VRES+V_FP+V_SYNC`, i.e. 490..491.
  - Visible when `x < HRES && y < VRES`.
- Raw hsync, vsync and visible pass through a `RENDER_LAT`-deep shift register, then a final output register.
- RGB path: `red/green/blue` are registered as `in_*` when the delayed visible bit is 1, else forced to 0.
- `vga_clk` is registered `div >= PIX_DIV/2`.

## Timing
- Reset values: `x=y=0`, `div=0`, `pix_en=line_start=frame_start=0`, `hsync=vsync=1`, `blank_n=0`, RGB=0, `vga_clk=0`. All delay-line stages reset to the inactive values: sync 1, visible 0.
- Reset asserted mid-frame forces these values immediately. After deassertion, `x=0,y=0` is held for PIX_DIV `clk` cycles before the first advance. `frame_start` is not pulsed for the post-reset frame.
- Latency: counter state at `clk` edge t appears on `hsync/vsync/blank_n/RGB` at edge t+RENDER_LAT+1. All four change on the same edge.
- Counters change only on `pix_en` edges, so `x`/`y` are stable for PIX_DIV `clk` cycles.
- Frame period is H_TOTAL·V_TOTAL·PIX_DIV `clk` cycles (840000 by default).
- Arithmetic is unsigned. Counters are 10 bits; the parameters must keep H_TOTAL and V_TOTAL ≤ 1024 (elaboration assertion).

## Structure
- Package `vga_pkg`:
  - default timing constants
  - derived H_TOTAL/V_TOTAL and sync start/end localparams
  - a packed struct `vga_ctl_t` {hsync, vsync, visible} carried through the delay line
- Sub-module `vga_delay_line`: parameterized width/depth shift register with async reset to a parameterized value. It is instantiated once for `vga_ctl_t`.

## Test plan
- Reset: assert `rst` mid-stream → all outputs at reset values in the same cycle. After release, first `pix_en` at cycle PIX_DIV, with `x` becoming 1.
- Line: count `pix_en` between `line_start` pulses → exactly 800. Raw hsync low for 96 pixels starting at x=656; output hsync low exactly RENDER_LAT+1 `clk` later.
- Frame: `frame_start` pulses 840000 `clk` apart. vsync low for lines 490–491 (1600 pixels). `y` never exceeds 524.
- Blank alignment: drive `in_*`=8'hFF constantly → output RGB=FF only while `blank_n=1`, 0 otherwise. `blank_n` rises RENDER_LAT+1 `clk` after `x` returns to 0 on visible lines.
- Latency: renderer model returns `in_red = x[7:0]` with RENDER_LAT delay → `red` equals the x of the same pixel, for all visible pixels.
- Parameter sweep: PIX_DIV=4, RENDER_LAT=3 → frame period 1680000 and alignment checks still pass.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Brief    : Default 640x480@60 timing constants and the control bundle
//             carried through the sync/blank delay line.
//  Revision : 1.0
// ============================================================================
package vga_pkg;

   localparam int c_hres   = 640;
   localparam int c_vres   = 480;
   localparam int c_h_fp   = 16;
   localparam int c_h_sync = 96;
   localparam int c_h_bp   = 48;
   localparam int c_v_fp   = 10;
   localparam int c_v_sync = 2;
   localparam int c_v_bp   = 33;

   localparam int c_h_total    = c_hres + c_h_fp + c_h_sync + c_h_bp;
   localparam int c_v_total    = c_vres + c_v_fp + c_v_sync + c_v_bp;
   localparam int c_hs_start   = c_hres + c_h_fp;
   localparam int c_hs_end     = c_hs_start + c_h_sync;
   localparam int c_vs_start   = c_vres + c_v_fp;
   localparam int c_vs_end     = c_vs_start + c_v_sync;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic visible;
   } vga_ctl_t;

   // Inactive level for every delay-line stage: syncs high, not visible
   localparam vga_ctl_t c_ctl_idle = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0};

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : vga_delay_line
//  Brief    : Fixed-depth shift register with async reset to a given value.
//  Revision : 1.0
// ============================================================================
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);

   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= RESET_VAL;
      end else begin
         r_sr[0] <= i_din;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_dout = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : VGA raster counters, pixel enable, and latency-matched
//             sync/blank/RGB output stage.
//  Revision : 1.0
// ============================================================================
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int HRES       = c_hres,
   parameter int VRES       = c_vres,
   parameter int H_FP       = c_h_fp,
   parameter int H_SYNC     = c_h_sync,
   parameter int H_BP       = c_h_bp,
   parameter int V_FP       = c_v_fp,
   parameter int V_SYNC     = c_v_sync,
   parameter int V_BP       = c_v_bp,
   parameter int PIX_DIV    = 2,
   parameter int RENDER_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pix_en,
   output logic       line_start,
   output logic       frame_start,
   input  logic [7:0] in_red,
   input  logic [7:0] in_green,
   input  logic [7:0] in_blue,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic       hsync,
   output logic       vsync,
   output logic       blank_n,
   output logic       sync_n,
   output logic       vga_clk
);

   localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(PIX_DIV - 1);
   localparam logic [DIV_W-1:0] c_div_half = DIV_W'(PIX_DIV / 2);
   localparam logic [9:0]       c_x_last   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       c_y_last   = 10'(V_TOTAL - 1);
   // 11-bit decode bounds so an end value of exactly 1024 still compares
   localparam logic [10:0]      c_hs_lo    = 11'(HRES + H_FP);
   localparam logic [10:0]      c_hs_hi    = 11'(HRES + H_FP + H_SYNC);
   localparam logic [10:0]      c_vs_lo    = 11'(VRES + V_FP);
   localparam logic [10:0]      c_vs_hi    = 11'(VRES + V_FP + V_SYNC);
   localparam logic [10:0]      c_h_vis    = 11'(HRES);
   localparam logic [10:0]      c_v_vis    = 11'(VRES);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counters");
   end
   if (PIX_DIV < 2 || RENDER_LAT < 1) begin : g_bad_div_lat
      $error("vga_timing_gen: PIX_DIV must be >= 2 and RENDER_LAT >= 1");
   end

   logic [DIV_W-1:0] r_div;
   logic [9:0]       r_x, r_y;
   logic             r_pix_en, r_line_start, r_frame_start, r_vga_clk;
   logic             w_tick;
   vga_ctl_t         w_raw, w_dly, r_out;
   logic [7:0]       r_red, r_green, r_blue;

   assign w_tick = (r_div == c_div_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div         <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_pix_en      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_vga_clk     <= 1'b0;
      end else begin
         r_div         <= w_tick ? '0 : r_div + 1'b1;
         r_pix_en      <= w_tick;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_vga_clk     <= (r_div >= c_div_half);
         if (w_tick) begin
            if (r_x == c_x_last) begin
               r_x          <= '0;
               r_line_start <= 1'b1;
               if (r_y == c_y_last) begin
                  r_y           <= '0;
                  r_frame_start <= 1'b1;
               end else begin
                  r_y <= r_y + 1'b1;
               end
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_raw         = c_ctl_idle;
      w_raw.hsync   = !(({1'b0, r_x} >= c_hs_lo) && ({1'b0, r_x} < c_hs_hi));
      w_raw.vsync   = !(({1'b0, r_y} >= c_vs_lo) && ({1'b0, r_y} < c_vs_hi));
      w_raw.visible = ({1'b0, r_x} < c_h_vis) && ({1'b0, r_y} < c_v_vis);
   end

   // Matches the renderer's latency so control meets its colour data
   vga_delay_line #(
      .WIDTH     ($bits(vga_ctl_t)),
      .DEPTH     (RENDER_LAT),
      .RESET_VAL (c_ctl_idle)
   ) u_ctl_dly (
      .clk    (clk),
      .rst    (rst),
      .i_din  (w_raw),
      .o_dout (w_dly)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= c_ctl_idle;
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else begin
         r_out   <= w_dly;
         r_red   <= w_dly.visible ? in_red   : 8'h00;
         r_green <= w_dly.visible ? in_green : 8'h00;
         r_blue  <= w_dly.visible ? in_blue  : 8'h00;
      end
   end

   assign x           = r_x;
   assign y           = r_y;
   assign pix_en      = r_pix_en;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign red         = r_red;
   assign green       = r_green;
   assign blue        = r_blue;
   assign hsync       = r_out.hsync;
   assign vsync       = r_out.vsync;
   assign blank_n     = r_out.visible;
   assign sync_n      = 1'b0;
   assign vga_clk     = r_vga_clk;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Directed bench: default 640x480 instance plus a shrunken-raster
//             instance with PIX_DIV=4, RENDER_LAT=3 for frame-level timing.
//  Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;

   localparam int NCYC = 3220;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [9:0] x0, y0, x1, y1;
   logic       pe0, ls0, fs0, hs0, vs0, bn0, sn0, vc0;
   logic       pe1, ls1, fs1, hs1, vs1, bn1, sn1, vc1;
   logic [7:0] r0, g0, b0, r1, g1, b1;
   logic [7:0] ir0, p1a, p1b, ir1;

   // Renderer models: red = x of the pixel, delayed by RENDER_LAT clocks
   always @(posedge clk) ir0 <= x0[7:0];
   always @(posedge clk) begin
      p1a <= x1[7:0];
      p1b <= p1a;
      ir1 <= p1b;
   end

   vga_timing_gen u_dut0 (
      .clk(clk), .rst(rst), .x(x0), .y(y0), .pix_en(pe0), .line_start(ls0),
      .frame_start(fs0), .in_red(ir0), .in_green(8'hFF), .in_blue(8'hFF),
      .red(r0), .green(g0), .blue(b0), .hsync(hs0), .vsync(vs0),
      .blank_n(bn0), .sync_n(sn0), .vga_clk(vc0)
   );

   // 16x8 total raster: visible 8x4, hsync x=10..12, vsync y=5..6
   vga_timing_gen #(
      .HRES(8), .VRES(4), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_FP(1), .V_SYNC(2), .V_BP(1), .PIX_DIV(4), .RENDER_LAT(3)
   ) u_dut1 (
      .clk(clk), .rst(rst), .x(x1), .y(y1), .pix_en(pe1), .line_start(ls1),
      .frame_start(fs1), .in_red(ir1), .in_green(8'hFF), .in_blue(8'hFF),
      .red(r1), .green(g1), .blue(b1), .hsync(hs1), .vsync(vs1),
      .blank_n(bn1), .sync_n(sn1), .vga_clk(vc1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   int xh0 [0:NCYC], yh0 [0:NCYC], xh1 [0:NCYC], yh1 [0:NCYC];

   initial begin
      int  xk, yk;
      bit  vis;
      int  e_hs0, e_vs0, e_bn0, e_rgb0, e_vc0;
      int  e_hs1, e_vs1, e_bn1, e_rgb1, e_vc1;
      int  pc0, n_ls0, len0, last_ls0, rise0, hs_low0, hs_fall0, n_fs0;
      int  pc1, n_ls1, len1, fs1_a, fs1_b, ymax1, vs_low1;
      logic bn0_prev, hs0_prev;

      e_hs0 = 0; e_vs0 = 0; e_bn0 = 0; e_rgb0 = 0; e_vc0 = 0;
      e_hs1 = 0; e_vs1 = 0; e_bn1 = 0; e_rgb1 = 0; e_vc1 = 0;
      pc0 = 0; n_ls0 = 0; len0 = -1; last_ls0 = -1; rise0 = -1;
      hs_low0 = 0; hs_fall0 = -1; n_fs0 = 0;
      pc1 = 0; n_ls1 = 0; len1 = -1; fs1_a = -1; fs1_b = -1; ymax1 = 0; vs_low1 = 0;

      rst = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_x", x0, 0);
      chk("rst_y", y0, 0);
      chk("rst_pix_en", pe0, 0);
      chk("rst_line_start", ls0, 0);
      chk("rst_hsync", hs0, 1);
      chk("rst_vsync", vs0, 1);
      chk("rst_blank_n", bn0, 0);
      chk("rst_red", r0, 0);
      chk("rst_green", g0, 0);
      chk("rst_vga_clk", vc0, 0);
      chk("sync_n", sn0, 0);
      chk("rst_sync_n_p4", sn1, 0);

      xh0[0] = 0; yh0[0] = 0; xh1[0] = 0; yh1[0] = 0;
      bn0_prev = bn0; hs0_prev = hs0;
      rst = 1'b0;

      for (int c = 1; c <= NCYC; c++) begin
         @(posedge clk);
         #1;
         xh0[c] = int'(x0); yh0[c] = int'(y0);
         xh1[c] = int'(x1); yh1[c] = int'(y1);

         if (c == 1) begin
            chk("c1_pix_en", pe0, 0);
            chk("c1_x_held", x0, 0);
            chk("c1_vga_clk", vc0, 0);
         end
         if (c == 2) begin
            chk("first_pix_en", pe0, 1);
            chk("first_x", x0, 1);
            chk("first_line_start", ls0, 0);
            chk("first_frame_start", fs0, 0);
         end
         if (c == 3) chk("p4_c3_pix_en", pe1, 0);
         if (c == 4) begin
            chk("p4_first_pix_en", pe1, 1);
            chk("p4_first_x", x1, 1);
         end

         // default instance: outputs reflect counters from 2 clocks earlier
         if (c >= 2) begin
            xk  = xh0[c-2]; yk = yh0[c-2];
            vis = (xk < 640) && (yk < 480);
            if (hs0 !== !(xk >= 656 && xk < 752)) e_hs0++;
            if (vs0 !== !(yk >= 490 && yk < 492)) e_vs0++;
            if (bn0 !== vis) e_bn0++;
            if (r0 !== (vis ? 8'(xk) : 8'h00) || g0 !== (vis ? 8'hFF : 8'h00) ||
                b0 !== (vis ? 8'hFF : 8'h00)) e_rgb0++;
         end
         if (vc0 !== (((c - 1) % 2) >= 1)) e_vc0++;
         if (pe0) pc0++;
         if (ls0) begin
            if (n_ls0 == 1) len0 = pc0;
            n_ls0++; pc0 = 0; last_ls0 = c;
         end
         if (fs0) n_fs0++;
         if (bn0 && !bn0_prev && c > 2) rise0 = c;
         if (!hs0) hs_low0++;
         if (!hs0 && hs0_prev && hs_fall0 < 0) hs_fall0 = c;
         bn0_prev = bn0; hs0_prev = hs0;

         // shrunken instance: RENDER_LAT=3, so outputs lag counters by 4
         if (c >= 4) begin
            xk  = xh1[c-4]; yk = yh1[c-4];
            vis = (xk < 8) && (yk < 4);
            if (hs1 !== !(xk >= 10 && xk < 13)) e_hs1++;
            if (vs1 !== !(yk >= 5 && yk < 7)) e_vs1++;
            if (bn1 !== vis) e_bn1++;
            if (r1 !== (vis ? 8'(xk) : 8'h00) || g1 !== (vis ? 8'hFF : 8'h00) ||
                b1 !== (vis ? 8'hFF : 8'h00)) e_rgb1++;
         end
         if (vc1 !== (((c - 1) % 4) >= 2)) e_vc1++;
         if (pe1) pc1++;
         if (ls1) begin
            if (n_ls1 == 1) len1 = pc1;
            n_ls1++; pc1 = 0;
         end
         if (fs1) begin
            if (fs1_a < 0) fs1_a = c;
            else if (fs1_b < 0) fs1_b = c;
         end
         if (int'(y1) > ymax1) ymax1 = int'(y1);
         if (c <= 512 && !vs1) vs_low1++;
      end

      chk("hsync_align", e_hs0, 0);
      chk("vsync_align", e_vs0, 0);
      chk("blank_align", e_bn0, 0);
      chk("rgb_align", e_rgb0, 0);
      chk("vga_clk_pattern", e_vc0, 0);
      chk("line_pix_en_count", len0, 800);
      chk("line_start_count", n_ls0, 2);
      chk("blank_rise_after_wrap", rise0 - last_ls0, 2);
      chk("hsync_first_fall", hs_fall0, 1314);
      chk("hsync_low_clks", hs_low0, 384);
      chk("no_frame_start", n_fs0, 0);
      chk("end_x", x0, 10);
      chk("end_y", y0, 2);

      chk("p4_hsync_align", e_hs1, 0);
      chk("p4_vsync_align", e_vs1, 0);
      chk("p4_blank_align", e_bn1, 0);
      chk("p4_rgb_align", e_rgb1, 0);
      chk("p4_vga_clk_pattern", e_vc1, 0);
      chk("p4_line_len", len1, 16);
      chk("p4_first_frame_start", fs1_a, 512);
      chk("p4_frame_period", fs1_b - fs1_a, 512);
      chk("p4_y_max", ymax1, 7);
      chk("p4_vsync_low_clks", vs_low1, 128);

      // asynchronous reset in the middle of a visible line
      @(negedge clk);
      chk("pre_rst_blank_n", bn0, 1);
      chk("pre_rst_pix_en", pe0, 1);
      #1 rst = 1'b1;
      #1;
      chk("async_x", x0, 0);
      chk("async_pix_en", pe0, 0);
      chk("async_blank_n", bn0, 0);
      chk("async_red", r0, 0);
      chk("async_hsync", hs0, 1);
      chk("async_vga_clk", vc0, 0);
      chk("async_p4_x", x1, 0);
      chk("async_p4_y", y1, 0);
      chk("async_p4_green", g1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
